// File: rtl/phaseseq_pkg.sv
// Shared constants and helpers for the phase sequencer and its timer.
package phaseseq_pkg;

  localparam int MAX_PHASES = 8;
  localparam int ST_IDLE    = 0;

  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Strobe vector for phase k (1-based); all zeros outside 1..n.
  function automatic logic [MAX_PHASES-1:0] phase_onehot(input int k, input int n);
    logic [MAX_PHASES-1:0] oh;
    oh = '0;
    if (k >= 1 && k <= n && k <= MAX_PHASES) oh = {{(MAX_PHASES-1){1'b0}}, 1'b1} << (k - 1);
    return oh;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase clock down-counter; the final clock is held while stalled.
// With PHASESEQ_STALL_TIMEOUT_EN a consecutive-stall counter overrides the hold at STALL_LIMIT.
module phase_timer #(
  parameter int PHASE_CYCLES = 1,
  parameter int STALL_LIMIT  = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic stall_i,
  output logic adv_o,
  output logic timeout_o
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  logic          timeout_hit;

  assign last  = (cnt_q == '0);
  assign adv_o = run_i && last && (!stall_i || timeout_hit);

  // Parked at LOAD while idle so phase 1 starts with a full count.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || adv_o) cnt_d = LOAD;
    else if (!last)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= LOAD;
    else       cnt_q <= cnt_d;
  end

`ifdef PHASESEQ_STALL_TIMEOUT_EN
  localparam int SCW = $clog2(STALL_LIMIT + 1);

  logic [SCW-1:0] scnt_q, scnt_d;

  assign timeout_hit = run_i && last && stall_i && (scnt_q == SCW'(STALL_LIMIT));

  always_comb begin
    scnt_d = scnt_q;
    if (!run_i || adv_o)     scnt_d = '0;
    else if (last && stall_i) scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) scnt_q <= '0;
    else       scnt_q <= scnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign timeout_o = timeout_hit;

endmodule

// File: rtl/phase_sequencer.sv
// N-phase instruction sequencer: one-hot phase strobes, run/halt/step control, retired count.
// Optional stall timeout is enabled by defining PHASESEQ_STALL_TIMEOUT_EN.
module phase_sequencer
  import phaseseq_pkg::*;
#(
  parameter int NUM_PHASES   = 3,
  parameter int PHASE_CYCLES = 1,
  parameter int COUNT_W      = 16,
  parameter int STALL_LIMIT  = 255
) (
  input  logic                          i_CLOCK,
  input  logic                          i_RESET,
  input  logic                          i_RUN,
  input  logic                          i_STEP,
  input  logic                          i_HALT,
  input  logic                          i_STALL,
  output logic [NUM_PHASES-1:0]         o_CYCLE,
  output logic [state_w(NUM_PHASES)-1:0] o_STATE,
  output logic                          o_INSTR_DONE,
  output logic                          o_HALTED,
  output logic [COUNT_W-1:0]            o_ICOUNT,
  output logic                          o_STALL_TIMEOUT
);

  localparam int SW = state_w(NUM_PHASES);
  localparam logic [SW-1:0] IDLE    = SW'(ST_IDLE);
  localparam logic [SW-1:0] FIRST   = SW'(1);
  localparam logic [SW-1:0] LAST_PH = SW'(NUM_PHASES);

  function automatic logic [NUM_PHASES-1:0] strobe(input logic [SW-1:0] k);
    logic [MAX_PHASES-1:0] oh;
    oh = phase_onehot(int'(k), NUM_PHASES);
    return oh[NUM_PHASES-1:0];
  endfunction

  logic [SW-1:0]         state_q;
  logic [NUM_PHASES-1:0] cycle_q;
  logic                  halted_q, halt_pend_q, step_q;
  logic [COUNT_W-1:0]    icount_q;
  logic                  running, adv, timeout_hit, instr_end;

  assign running   = (state_q != IDLE);
  assign instr_end = adv && (state_q == LAST_PH);

  phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_timer (
    .clk_i    (i_CLOCK),
    .rst_i    (i_RESET),
    .run_i    (running),
    .stall_i  (i_STALL),
    .adv_o    (adv),
    .timeout_o(timeout_hit)
  );

`ifdef PHASESEQ_STALL_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge i_CLOCK or posedge i_RESET) begin
    if (i_RESET)          timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  assign o_STALL_TIMEOUT = timeout_q;
`else
  assign o_STALL_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge i_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q     <= IDLE;
      cycle_q     <= '0;
      halted_q    <= 1'b1;
      halt_pend_q <= 1'b0;
      step_q      <= 1'b0;
      icount_q    <= '0;
    end else begin
      cycle_q <= '0;
      if (!running) begin
        if (i_RUN || i_STEP) begin
          state_q  <= FIRST;
          cycle_q  <= strobe(FIRST);
          halted_q <= 1'b0;
          step_q   <= i_STEP;
        end
      end else begin
        if (i_HALT || timeout_hit) halt_pend_q <= 1'b1;
        if (adv) begin
          if (state_q == LAST_PH) begin
            icount_q <= icount_q + 1'b1;
            // Halt sampled on the boundary edge itself still stops here.
            if (halt_pend_q || i_HALT || step_q || timeout_hit) begin
              state_q     <= IDLE;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
              step_q      <= 1'b0;
            end else begin
              state_q <= FIRST;
              cycle_q <= strobe(FIRST);
            end
          end else begin
            state_q <= state_q + 1'b1;
            cycle_q <= strobe(state_q + 1'b1);
          end
        end
      end
    end
  end

  assign o_STATE      = state_q;
  assign o_CYCLE      = cycle_q;
  assign o_HALTED     = halted_q;
  assign o_ICOUNT     = icount_q;
  assign o_INSTR_DONE = instr_end;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer (3 phases x 2 clocks, 4-bit count).
// Timeout expectations follow PHASESEQ_STALL_TIMEOUT_EN when it is defined.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, step, halt, stall;
  logic [2:0] o_cycle;
  logic [1:0] o_state;
  logic       o_done, o_halted, o_timeout;
  logic [3:0] o_icount;

  typedef struct {
    int t;
    bit kind;
    int val;
  } ev_t;

  ev_t sb[$];
  int  cnt = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  mcount = 0;

  phase_sequencer #(
    .NUM_PHASES  (3),
    .PHASE_CYCLES(2),
    .COUNT_W     (4),
    .STALL_LIMIT (4)
  ) dut (
    .i_CLOCK        (clk),
    .i_RESET        (rst),
    .i_RUN          (run),
    .i_STEP         (step),
    .i_HALT         (halt),
    .i_STALL        (stall),
    .o_CYCLE        (o_cycle),
    .o_STATE        (o_state),
    .o_INSTR_DONE   (o_done),
    .o_HALTED       (o_halted),
    .o_ICOUNT       (o_icount),
    .o_STALL_TIMEOUT(o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (period %0d)", nm, act, exp, cnt);
    end
  endtask

  task automatic push(input int t, input bit kind, input int val);
    ev_t e;
    e.t = t; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  // Expected strobes/done for one instruction starting at period e, s extra clocks stalled in phase 2.
  task automatic push_instr(input int e, input int s, output int nxt);
    push(e, 1'b0, 1);
    push(e + 2, 1'b0, 2);
    push(e + 4 + s, 1'b0, 4);
    push(e + 5 + s, 1'b1, mcount);
    mcount = (mcount + 1) % 16;
    nxt = e + 6 + s;
  endtask

  task automatic at(input int p);
    while (cnt < p) @(negedge clk);
  endtask

  task automatic observe(input bit kind, input int val);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: kind=%0d val=%0d at period %0d, none queued", kind, val, cnt);
    end else begin
      e = sb.pop_front();
      if (e.t != cnt || e.kind != kind || e.val != val) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%0d at %0d, expected kind=%0d val=%0d at %0d",
                 kind, val, cnt, e.kind, e.val, e.t);
      end
    end
  endtask

  // Monitor: sampled late in the low phase, after any stimulus change.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (o_cycle != 3'b000) observe(1'b0, int'(o_cycle));
      if (o_done)            observe(1'b1, int'(o_icount));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, nx;
    rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_cycle", o_cycle, 0);
    chk("rst_done", o_done, 0);
    chk("rst_halted", o_halted, 1);
    chk("rst_icount", o_icount, 0);
    chk("rst_timeout", o_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous run: plain instruction, then one with a 3-clock stall in phase 2.
    at(cnt + 2);
    run = 1'b1; e = cnt + 1;
    @(negedge clk);
    run = 1'b0;
    push_instr(e, 0, e);
    at(e); #1;
    chk("run_state_next", o_state, 1);
    chk("run_icount", o_icount, 1);
    chk("run_halted", o_halted, 0);
    push_instr(e, 3, nx);
    at(e + 2);
    stall = 1'b1;
    at(e + 6);
    stall = 1'b0;

    // Halt (with simultaneous run) during phase 1.
    e = nx;
    push_instr(e, 0, nx);
    at(e);
    halt = 1'b1; run = 1'b1;
    at(e + 1);
    halt = 1'b0; run = 1'b0;
    at(nx); #1;
    chk("halt_state", o_state, 0);
    chk("halt_halted", o_halted, 1);
    chk("halt_icount", o_icount, 3);
    at(nx + 3);

    // Single step, then step with run together.
    step = 1'b1; e = cnt + 1;
    @(negedge clk);
    step = 1'b0;
    push_instr(e, 0, nx);
    at(nx); #1;
    chk("step_state", o_state, 0);
    chk("step_halted", o_halted, 1);
    chk("step_icount", o_icount, 4);
    at(nx + 2);
    step = 1'b1; run = 1'b1; e = cnt + 1;
    @(negedge clk);
    step = 1'b0; run = 1'b0;
    push_instr(e, 0, nx);
    at(nx); #1;
    chk("steprun_state", o_state, 0);
    chk("steprun_halted", o_halted, 1);
    chk("steprun_icount", o_icount, 5);

    // Halt while idle is dropped; run 11 instructions to wrap the count.
    at(cnt + 2);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; run = 1'b1; e = cnt + 1;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 11; i++) push_instr(e, 0, e);
    at(e); #1;
    chk("wrap_icount", o_icount, 0);
    chk("wrap_state", o_state, 1);
    push(e, 1'b0, 1);
    push(e + 2, 1'b0, 2);

    // Asynchronous reset on the last clock of phase 2.
    at(e + 3); #2;
    rst = 1'b1;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_cycle", o_cycle, 0);
    chk("arst_done", o_done, 0);
    chk("arst_halted", o_halted, 1);
    chk("arst_icount", o_icount, 0);
    mcount = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Permanent stall from the final clock of phase 1.
    at(cnt + 2);
    run = 1'b1; e = cnt + 1;
    @(negedge clk);
    run = 1'b0;
`ifdef PHASESEQ_STALL_TIMEOUT_EN
    push(e, 1'b0, 1);
    push(e + 6, 1'b0, 2);
    push(e + 12, 1'b0, 4);
    push(e + 17, 1'b1, 0);
    at(e + 1);
    stall = 1'b1;
    at(e + 18); #1;
    chk("tmo_state", o_state, 0);
    chk("tmo_halted", o_halted, 1);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_icount", o_icount, 1);
    stall = 1'b0;
`else
    push(e, 1'b0, 1);
    at(e + 1);
    stall = 1'b1;
    at(e + 25); #1;
    chk("hold_state", o_state, 1);
    chk("hold_icount", o_icount, 0);
    chk("hold_timeout", o_timeout, 0);
    rst = 1'b1; stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif

    at(cnt + 4);
    chk("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
